sp_inst_feeder: RTL

SP_INST_FEEDER -- requirements
Module: sp_inst_feeder

---
 rtl/sp_pkg.sv | 21 ++
 rtl/sp_inst_rom.sv | 26 ++
 rtl/sp_inst_feeder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sp_pkg.sv
// Shared types for the instruction feeder: FSM state encoding and failure cause codes.
package sp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GAP,
      ST_ISSUE,
      ST_WAIT,
      ST_SETTLE,
      ST_DONE,
      ST_FAIL
   } state_t;

   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_TIMEOUT  = 3'd1;
   localparam logic [2:0] ERR_DOUBLE   = 3'd2;
   localparam logic [2:0] ERR_UNEXP    = 3'd3;
   localparam logic [2:0] ERR_MISALIGN = 3'd4;
   localparam logic [2:0] ERR_RANGE    = 3'd5;

endpackage

// File: rtl/sp_inst_rom.sv
// Instruction store: clocked write port, combinational read port.
module sp_inst_rom #(
   parameter int DATA_W    = 32,
   parameter int ROM_DEPTH = 1024,
   parameter int ADDR_W    = $clog2(ROM_DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [ROM_DEPTH];

   // No reset on the array so that contents survive a mid-run reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sp_inst_feeder.sv
// Issues ROM instructions to a processor one at a time and polices the completion handshake.
module sp_inst_feeder
   import sp_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ROM_DEPTH = 1024,
   parameter int MAX_LAT   = 10,
   parameter int PAT_NUM   = 500
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         prog_we,
   input  logic [$clog2(ROM_DEPTH)-1:0] prog_addr,
   input  logic [DATA_W-1:0]            prog_data,
   input  logic                         start,
   input  logic [1:0]                   gap_cycles,
   output logic                         in_valid,
   output logic [DATA_W-1:0]            inst,
   input  logic                         out_valid,
   input  logic [DATA_W-1:0]            inst_addr,
   output logic                         busy,
   output logic                         done,
   output logic                         pass,
   output logic [2:0]                   err_code,
   output logic [15:0]                  pat_cnt,
   output logic [3:0]                   lat_cnt
);

   localparam int ADDR_W = $clog2(ROM_DEPTH);

   state_t            state;
   state_t            next_state;
   logic [2:0]        fail_code;
   logic [DATA_W-1:0] pc;
   logic [DATA_W-1:0] rom_data;
   logic [1:0]        gap_cnt;
   logic              start_ok;

   assign start_ok = start && !busy;

   sp_inst_rom #(
      .DATA_W   (DATA_W),
      .ROM_DEPTH(ROM_DEPTH)
   ) u_rom (
      .clk    (clk),
      .we     (prog_we && !busy),
      .wr_addr(prog_addr),
      .wr_data(prog_data),
      .rd_addr(pc[ADDR_W+1:2]),
      .rd_data(rom_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // fail_code is non-zero only on the cycle that moves into FAIL; it also feeds err_code.
   always_comb begin
      next_state = state;
      fail_code  = ERR_NONE;
      case (state)
         ST_IDLE, ST_DONE, ST_FAIL: begin
            if (start) begin
               if (out_valid) begin
                  next_state = ST_FAIL;
                  fail_code  = ERR_UNEXP;
               end else if (gap_cycles != 2'd0) begin
                  next_state = ST_GAP;
               end else begin
                  next_state = ST_ISSUE;
               end
            end
         end
         ST_GAP: begin
            if (out_valid) begin
               next_state = ST_FAIL;
               fail_code  = ERR_UNEXP;
            end else if (gap_cnt == 2'd1) begin
               next_state = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (out_valid) begin
               next_state = ST_FAIL;
               fail_code  = ERR_UNEXP;
            end else begin
               next_state = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (out_valid) begin
               next_state = ST_SETTLE;
            end else if (lat_cnt == 4'(MAX_LAT - 1)) begin
               next_state = ST_FAIL;
               fail_code  = ERR_TIMEOUT;
            end
         end
         ST_SETTLE: begin
            if (out_valid) begin
               next_state = ST_FAIL;
               fail_code  = ERR_DOUBLE;
            end else if (pc[1:0] != 2'b00) begin
               next_state = ST_FAIL;
               fail_code  = ERR_MISALIGN;
            end else if ((pc >> 2) >= DATA_W'(ROM_DEPTH)) begin
               next_state = ST_FAIL;
               fail_code  = ERR_RANGE;
            end else if (pat_cnt == 16'(PAT_NUM)) begin
               next_state = ST_DONE;
            end else begin
               next_state = ST_ISSUE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      in_valid = (state == ST_ISSUE);
      inst     = in_valid ? rom_data : '0;
      busy     = (state == ST_GAP) || (state == ST_ISSUE) ||
                 (state == ST_WAIT) || (state == ST_SETTLE);
      done     = (state == ST_DONE) || (state == ST_FAIL);
      pass     = (state == ST_DONE);
   end

   // lat_cnt is left at its final value on a timeout so the stall length stays visible.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc       <= '0;
         pat_cnt  <= '0;
         lat_cnt  <= '0;
         gap_cnt  <= '0;
         err_code <= ERR_NONE;
      end else begin
         if (start_ok) begin
            pc      <= '0;
            pat_cnt <= '0;
            lat_cnt <= '0;
            gap_cnt <= gap_cycles;
         end else if (state == ST_GAP) begin
            gap_cnt <= gap_cnt - 2'd1;
         end else if (state == ST_WAIT) begin
            if (out_valid) begin
               pc      <= inst_addr;
               pat_cnt <= pat_cnt + 16'd1;
               lat_cnt <= '0;
            end else begin
               lat_cnt <= lat_cnt + 4'd1;
            end
         end
         if (fail_code != ERR_NONE) begin
            err_code <= fail_code;
         end else if (start_ok) begin
            err_code <= ERR_NONE;
         end
      end
   end

endmodule
